// File: rtl/fft_frame_buffer_pkg.sv
// Shared FFT definitions: default frame geometry and the bit-reversal helper
// used by both the frame buffer and the FFT core.
package fft_frame_buffer_pkg;

  localparam int FFT_N     = 8;
  localparam int FFT_IN_W  = 8;
  localparam int FFT_OUT_W = 9;

  // Reverse the low `bits` bits of idx; bits above `bits` are ignored.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < bits && idx[i]) r[bits-1-i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer in front of the FFT core: collects N samples per
// bank and presents a completed bank as one wide word until it is taken.
module fft_frame_buffer
  import fft_frame_buffer_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int IN_W   = FFT_IN_W,
  parameter int OUT_W  = FFT_OUT_W,
  parameter int BITREV = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [IN_W-1:0]        s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [N*OUT_W-1:0]     m_data,
  output logic [$clog2(N):0]     fill_level
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = IDX_W + 1;

  logic [OUT_W-1:0] bank [2][N];
  logic             wb;
  logic             rb;
  logic [1:0]       full;
  logic [IDX_W-1:0] wptr;

  logic             accept;
  logic             release_frame;
  logic             last_sample;
  logic [IDX_W-1:0] wslot;
  logic [OUT_W-1:0] wdata;

  assign s_ready       = !full[wb] && !flush;
  assign accept        = s_valid && s_ready;
  assign m_valid       = full[rb];
  assign release_frame = full[rb] && m_ready;
  assign last_sample   = (wptr == IDX_W'(N - 1));
  assign wdata         = {{(OUT_W - IN_W){1'b0}}, s_data};
  assign fill_level    = CNT_W'(wptr);

  // Reordering happens on the write side so the read side is a plain register view.
  assign wslot = (BITREV != 0) ? IDX_W'(bitrev(32'(wptr), IDX_W)) : wptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb   <= 1'b0;
      rb   <= 1'b0;
      full <= '0;
      wptr <= '0;
      // NOTE: bank storage is reset too, so m_data reads zero after reset
      // instead of stale samples from before it.
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          bank[b][k] <= '0;
        end
      end
    end else begin
      // NOTE: non-blocking assignments here, so every test of wb/rb/wptr in
      // this block sees the value from before the edge.
      if (flush) begin
        wptr <= '0;
      end else if (accept) begin
        bank[wb][wslot] <= wdata;
        if (last_sample) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
          wptr     <= '0;
        end else begin
          wptr <= wptr + IDX_W'(1);
        end
      end
      // Completion needs !full[wb] and release needs full[rb], so when both
      // fire they always touch different banks.
      if (release_frame) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end
    end
  end

  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    m_data = '0;
    for (int k = 0; k < N; k++) begin
      m_data[k*OUT_W +: OUT_W] = bank[rb][k];
    end
  end

endmodule

// File: doc/fft_frame_buffer.md
FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

Interface
REQ-001 SHALL have parameter N, default 8, meaning samples per frame; legal values are powers of two, 2..16.
REQ-002 SHALL have parameter IN_W, default 8, meaning input sample width.
REQ-003 SHALL have parameter OUT_W, default 9, meaning per-sample output width; OUT_W > IN_W.
REQ-004 SHALL have parameter BITREV, default 0, meaning output sample order (0 natural, 1 bit-reversed index).
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port flush, input, 1, discard partial frame.
REQ-008 SHALL have port s_valid, input, 1, input sample valid.
REQ-009 SHALL have port s_ready, output, 1, input sample accepted when high with s_valid.
REQ-010 SHALL have port s_data, input, IN_W, unsigned input sample.
REQ-011 SHALL have port m_valid, output, 1, complete frame available.
REQ-012 SHALL have port m_ready, input, 1, downstream FFT takes the frame.
REQ-013 SHALL have port m_data, output, N*OUT_W, frame; slot k at bits [k*OUT_W +: OUT_W].
REQ-014 SHALL have port fill_level, output, $clog2(N)+1, samples held in the bank being filled.

Function
REQ-015 SHALL hold two banks of N samples (ping-pong), a write-bank pointer wb, a read-bank pointer rb, a write index wptr and full flags full[1:0].
REQ-016 SHALL drive s_ready = !full[wb] && !flush, combinationally.
REQ-017 SHALL, on accept, store {zero-extension, s_data} (OUT_W bits, MSB region 0) in bank[wb][wptr] and increment wptr.
REQ-018 SHALL, on the accept with wptr==N-1, set full[wb], toggle wb and clear wptr in the same edge.
REQ-019 SHALL drive m_valid = full[rb] and m_data from bank[rb] registers only (no combinational path from s_*).
REQ-020 SHALL place sample index i in slot i when BITREV=0, and in slot bitrev(i) when BITREV=1.
REQ-021 SHALL, on m_valid && m_ready, clear full[rb] and toggle rb.
REQ-022 SHALL apply completion (REQ-018) and release (REQ-021) in the same cycle when both occur, on their respective banks.
REQ-023 SHALL assert m_valid on the cycle after the Nth sample of a frame is accepted (latency 1 clk).
REQ-024 SHALL sustain 1 sample/clk indefinitely when m_ready is held high.
REQ-025 SHALL deassert s_ready only when both banks are full; it SHALL reassert on the cycle after a release.
REQ-026 SHALL keep m_data stable while m_valid is high and m_ready is low.
REQ-027 SHALL, on flush, clear wptr, drop the sample presented that cycle, and leave full banks and rb untouched.
REQ-028 SHALL report fill_level = wptr, range 0..N-1; N is never visible because completion clears wptr.

Reset
REQ-029 SHALL, on rst_n low at a clock edge, clear wptr, wb, rb, full[1:0] and all bank contents, regardless of any other input.
REQ-030 SHALL present s_ready=1, m_valid=0, m_data=0 and fill_level=0 on the cycle after reset; any partial or full frame held before reset is lost.

Structure
REQ-031 SHALL take default N, IN_W and OUT_W from the shared FFT package, together with the bitrev helper function, which is shared with the FFT core.
REQ-032 SHALL be implemented as a single module with no sub-modules; bank storage is flops.

Verification
REQ-033 Reset then samples 1..8 at 1/clk, m_ready=0 -> m_valid=1 one cycle after sample 8; slots 0..7 = 1..8; fill_level back to 0.
REQ-034 Continuous stream 0..23, m_ready=1, BITREV=0 -> three frames {0..7},{8..15},{16..23}; s_ready never drops.
REQ-035 m_ready=0, stream 16 samples -> s_ready=0 after sample 16; first m_ready pulse -> frame {0..7} released, s_ready=1 next cycle, m_data = {8..15}.
REQ-036 BITREV=1, samples 10..17 -> slot order 10,14,12,16,11,15,13,17.
REQ-037 Send 5 samples, flush concurrent with 6th, then 8 new samples 100..107 -> single frame {100..107}; no partial data output.
REQ-038 Frame completion coincident with m_ready release of the other bank -> both flags update, no frame lost or duplicated; rst_n low mid-frame -> m_valid=0, fill_level=0 next cycle.
